// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Holds the init/run state encoding and address-width helper.
package regfile_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_NRD  = 2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

    function automatic int rf_addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: range check, hardwired zero register, optional write forwarding.
// Latency: 0 cycles (pure combinational); backpressure: none.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREG     = DEF_NREG,
    parameter int AW       = rf_addr_w(DEF_NREG),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic            run,
    input  logic [AW-1:0]   raddr,
    input  logic [XLEN-1:0] mem_dat,
    input  logic            wr_ok,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic in_range;
    logic is_zero;

    assign in_range = (32'(raddr) < NREG);
    assign is_zero  = (ZERO_REG != 0) && (raddr == '0);

    always_comb begin
        rdata = '0;
        if (run && in_range && !is_zero) begin
            // wr_ok already excludes discarded writes, so only the address match matters here
            if ((BYPASS != 0) && wr_ok && (waddr == raddr)) begin
                rdata = wdata;
            end else begin
                rdata = mem_dat;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with self-clearing init sweep after reset.
// Latency: 1-cycle write, 0-cycle read; backpressure: none, ready low for NREG cycles after reset.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREG     = DEF_NREG,
    parameter int NRD      = DEF_NRD,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = rf_addr_w(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic                ready
);

    logic [XLEN-1:0] mem [NREG];

    rf_state_e       state, state_nxt;
    logic [AW-1:0]   clr_idx, clr_nxt;
    logic            run;
    logic            wr_ok;
    logic            mem_we;
    logic [AW-1:0]   mem_widx;
    logic [XLEN-1:0] mem_wdat;

    assign run   = (state == RUN);
    assign ready = run;

    // Reset dominates we; writes to out-of-range addresses or the zero register are dropped
    assign wr_ok = run && we && !reset && (32'(waddr) < NREG)
                   && !((ZERO_REG != 0) && (waddr == '0));

    always_comb begin
        state_nxt = state;
        clr_nxt   = clr_idx;
        mem_we    = 1'b0;
        mem_widx  = waddr;
        mem_wdat  = wdata;
        case (state)
            INIT: begin
                mem_we   = !reset;
                mem_widx = clr_idx;
                mem_wdat = '0;
                if (clr_idx == AW'(NREG - 1)) begin
                    state_nxt = RUN;
                    clr_nxt   = '0;
                end else begin
                    clr_nxt = clr_idx + 1'b1;
                end
            end
            RUN: begin
                mem_we = wr_ok;
            end
            default: begin
                state_nxt = INIT;
                clr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= INIT;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdat;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] mem_dat;

        assign ra      = raddr[k*AW +: AW];
        assign mem_dat = mem[ra];

        regfile_rd_port #(
            .XLEN     (XLEN),
            .NREG     (NREG),
            .AW       (AW),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .run     (run),
            .raddr   (ra),
            .mem_dat (mem_dat),
            .wr_ok   (wr_ok),
            .waddr   (waddr),
            .wdata   (wdata),
            .rdata   (rdata[k*XLEN +: XLEN])
        );
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, 32, data width in bits (>=8).
REQ-002 SHALL have parameter NREG, 32, number of registers (2..256, need not be power of 2).
REQ-003 SHALL have parameter NRD, 2, number of independent read ports (1..4).
REQ-004 SHALL have parameter BYPASS, 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL have parameter ZERO_REG, 1, 1 = register 0 hardwired to zero.
REQ-006 SHALL use derived constant AW = max(1, clog2(NREG)).
REQ-007 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port we  input  1  write enable.
REQ-010 SHALL have port waddr  input  AW  write address.
REQ-011 SHALL have port wdata  input  XLEN  write data.
REQ-012 SHALL have port raddr  input  NRD*AW  read addresses; port k in bits [k*AW +: AW].
REQ-013 SHALL have port rdata  output  NRD*XLEN  read data; port k in bits [k*XLEN +: XLEN].
REQ-014 SHALL have port ready  output  1  high once initialisation is complete.

Function
REQ-015 SHALL implement FSM states INIT and RUN; reset forces INIT with clear index 0.
REQ-016 In INIT, each cycle SHALL write 0 to register[index], then increment index; after index NREG-1 is cleared, next state is RUN.
REQ-017 INIT SHALL last exactly NREG cycles after reset deassertion; ready SHALL be 0 in INIT, 1 in RUN.
REQ-018 In INIT, we SHALL be ignored and every rdata port SHALL read 0.
REQ-019 In RUN, a write with we=1 SHALL update register[waddr] with wdata at the rising edge (1-cycle write latency).
REQ-020 Reads SHALL be combinational: rdata[k] = register[raddr[k]] in the same cycle, with no read latency.
REQ-021 With ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0.
REQ-022 Addresses >= NREG SHALL be out of range: such writes are discarded and such reads return 0.
REQ-023 With BYPASS=1, in RUN, if we=1 and waddr==raddr[k] and the write is not discarded, rdata[k] SHALL equal wdata in that cycle.
REQ-024 With BYPASS=0, rdata[k] SHALL show the old value until the edge following the write.
REQ-025 Multiple read ports addressing the same register SHALL return identical data.
REQ-026 A write while reading the same address on several ports SHALL forward to all matching ports.

Reset
REQ-027 reset high at any clock edge, including mid-INIT, SHALL restart INIT from index 0, drive ready=0, and read 0 on all ports from the following cycle.
REQ-028 While reset is high, writes SHALL be ignored; reset dominates we.
REQ-029 Register contents SHALL be deterministic (all zero) when ready first rises; no reliance on initial values.

Structure
REQ-030 Shared package regfile_pkg SHALL hold the FSM state enum (INIT, RUN) and default values for XLEN, NREG and NRD.
REQ-031 Sub-module regfile_rd_port SHALL be instantiated NRD times; each instance implements range check, zero-register and bypass mux for one port.
REQ-032 Storage, the clear counter and the FSM SHALL reside in regfile_mp.

Verification
REQ-033 Reset for 1 cycle, NREG=32: ready=0 for exactly 32 cycles, then 1; all reads return 0 during that window.
REQ-034 RUN, write 0xDEADBEEF to reg 5, then read on port 0 next cycle -> 0xDEADBEEF; port 1 reading reg 5 -> same value.
REQ-035 BYPASS=1: we=1, waddr=7, wdata=0x12345678, raddr0=7, same cycle -> rdata0=0x12345678; with BYPASS=0, old value (0) is read.
REQ-036 ZERO_REG=1: write 0xFFFFFFFF to reg 0 -> reads of reg 0 return 0, including the bypass cycle.
REQ-037 NREG=20: write to address 25 -> discarded; read of address 25 -> 0; reg 19 is written and read normally.
REQ-038 Write reg 3=0xA5A5A5A5, assert reset at INIT cycle 10 of a second reset -> ready stays 0 for 32 more cycles; afterwards reg 3 reads 0.
